// File: rtl/aurora_ctrl_pkg.sv
// aurora_ctrl_pkg: shared widths and TX buffer occupancy type for the Aurora data-path controller
package aurora_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W = 16;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/aurora_tx_skid.sv
// aurora_tx_skid: 2-entry TX output buffer with push/pop, occupancy and head output
module aurora_tx_skid
    import aurora_ctrl_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output occ_t         occ
);
    logic [W-1:0] tail;
    always_ff @(posedge clk) begin
        if (srst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            // new word lands in head when head is free after this cycle, else in tail
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
                head <= din;
            else if (pop && occ == 2'd2)
                head <= tail;
            if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop)))
                tail <= din;
        end
    end
endmodule

// File: rtl/aurora_fpga_ctrl.sv
// aurora_fpga_ctrl: user FIFO <-> Aurora AXI-stream data-path controller
// Define AURORA_CTRL_STATS_EN to add saturating tx/rx word and rx drop counters.
module aurora_fpga_ctrl #(
    parameter int DATA_W = aurora_ctrl_pkg::DATA_W
`ifdef AURORA_CTRL_STATS_EN
    , parameter int CNT_W = aurora_ctrl_pkg::CNT_W
`endif
) (
    input  logic              user_clk,
    input  logic              rst,
    input  logic              pll_not_locked,
    input  logic              rx_fifo_rst,
    input  logic              channel_rdy,
    input  logic [DATA_W-1:0] fifo_dat_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_o,
    output logic [DATA_W-1:0] fifo_wr_dat_o,
    output logic              fifo_wr_o,
    input  logic              fifo_full_i,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_data_src_rdy,
    input  logic              tx_data_dst_rdy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_data_src_rdy
`ifdef AURORA_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  tx_word_cnt,
    output logic [CNT_W-1:0]  rx_word_cnt,
    output logic [CNT_W-1:0]  rx_drop_cnt
`endif
);
    import aurora_ctrl_pkg::*;
    logic srst, pend, pop, accept;
    logic [2:0] fill;
    occ_t occ;
    assign srst = !rst | pll_not_locked;
    assign tx_data_src_rdy = channel_rdy & (occ != 2'd0);
    assign pop = tx_data_src_rdy & tx_data_dst_rdy;
    // projected occupancy once the in-flight word lands; a read is safe while it stays <= 1
    assign fill = 3'(occ) + 3'(pend) - 3'(pop);
    assign fifo_rd_o = !srst & channel_rdy & !fifo_empty_i & (fill <= 3'd1);
    assign accept = rx_data_src_rdy & channel_rdy & !fifo_full_i & !rx_fifo_rst;
    aurora_tx_skid #(.W(DATA_W)) u_skid (
        .clk  (user_clk),
        .srst (srst),
        .push (pend),
        .pop  (pop),
        .din  (fifo_dat_i),
        .head (tx_data),
        .occ  (occ)
    );
    always_ff @(posedge user_clk) begin
        if (srst) begin
            pend          <= 1'b0;
            fifo_wr_o     <= 1'b0;
            fifo_wr_dat_o <= '0;
        end else begin
            pend      <= fifo_rd_o;
            fifo_wr_o <= accept;
            if (accept)
                fifo_wr_dat_o <= rx_data;
        end
    end
`ifdef AURORA_CTRL_STATS_EN
    logic drop;
    assign drop = rx_data_src_rdy & !accept;
    always_ff @(posedge user_clk) begin
        if (srst)
            tx_word_cnt <= '0;
        else if (pop && tx_word_cnt != '1)
            tx_word_cnt <= tx_word_cnt + CNT_W'(1);
        if (srst || rx_fifo_rst) begin
            rx_word_cnt <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (accept && rx_word_cnt != '1)
                rx_word_cnt <= rx_word_cnt + CNT_W'(1);
            if (drop && rx_drop_cnt != '1)
                rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_aurora_fpga_ctrl.sv
// tb_aurora_fpga_ctrl: scoreboard bench for aurora_fpga_ctrl with a read-latency-1 TX FIFO model
module tb_aurora_fpga_ctrl;
    logic        user_clk = 0, rst = 0, pll_not_locked = 0, rx_fifo_rst = 0, channel_rdy = 1;
    logic [31:0] fifo_dat_i = '0, rx_data = '0;
    logic        fifo_empty_i = 1, fifo_full_i = 0, tx_data_dst_rdy = 1, rx_data_src_rdy = 0;
    logic        fifo_rd_o, fifo_wr_o, tx_data_src_rdy;
    logic [31:0] fifo_wr_dat_o, tx_data, held;
    logic [31:0] src_q[$], tx_exp[$], rx_exp[$];
    int          checks = 0, errors = 0, rd_cnt = 0, rd0, n, pops;
`ifdef AURORA_CTRL_STATS_EN
    logic [15:0] tx_word_cnt, rx_word_cnt, rx_drop_cnt;
`endif

    aurora_fpga_ctrl dut (
        .user_clk        (user_clk),
        .rst             (rst),
        .pll_not_locked  (pll_not_locked),
        .rx_fifo_rst     (rx_fifo_rst),
        .channel_rdy     (channel_rdy),
        .fifo_dat_i      (fifo_dat_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_rd_o       (fifo_rd_o),
        .fifo_wr_dat_o   (fifo_wr_dat_o),
        .fifo_wr_o       (fifo_wr_o),
        .fifo_full_i     (fifo_full_i),
        .tx_data         (tx_data),
        .tx_data_src_rdy (tx_data_src_rdy),
        .tx_data_dst_rdy (tx_data_dst_rdy),
        .rx_data         (rx_data),
        .rx_data_src_rdy (rx_data_src_rdy)
`ifdef AURORA_CTRL_STATS_EN
        ,
        .tx_word_cnt     (tx_word_cnt),
        .rx_word_cnt     (rx_word_cnt),
        .rx_drop_cnt     (rx_drop_cnt)
`endif
    );

    always #5 user_clk = ~user_clk;

    // TX source FIFO: data appears the cycle after the read strobe
    always @(posedge user_clk) begin
        if (fifo_rd_o) begin
            rd_cnt++;
            if (src_q.size() != 0)
                fifo_dat_i <= src_q.pop_front();
            fifo_empty_i <= (src_q.size() == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // monitor: every handshake/write is checked against the expected queues
    always @(negedge user_clk) begin
        #1;
        if (tx_data_src_rdy && tx_data_dst_rdy) begin
            if (tx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra: got 0x%08h, want no word", tx_data);
            end else
                chk("tx_word", tx_data, tx_exp.pop_front());
        end
        if (fifo_wr_o) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_extra: got 0x%08h, want no write", fifo_wr_dat_o);
            end else
                chk("rx_word", fifo_wr_dat_o, rx_exp.pop_front());
        end
    end

    task automatic cyc(input int k = 1);
        repeat (k) @(negedge user_clk);
    endtask

    task automatic load(input logic [31:0] base, input int k);
        for (int i = 0; i < k; i++) begin
            src_q.push_back(base + 32'(i));
            tx_exp.push_back(base + 32'(i));
        end
        fifo_empty_i = 0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((tx_exp.size() + rx_exp.size()) != 0 && t < 200) begin
            cyc();
            t++;
        end
        chk(name, 32'(tx_exp.size() + rx_exp.size()), 0);
    endtask

    initial begin
        load(32'h1, 16);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rst_rd", fifo_rd_o, 0);
            chk("rst_valid", tx_data_src_rdy, 0);
            chk("rst_wr", fifo_wr_o, 0);
        end
        cyc(); rst = 1; #1;
        chk("release_rd", fifo_rd_o, 1);
        n = 0;
        while (!tx_data_src_rdy && n < 10) begin cyc(); #1; n++; end
        chk("first_valid_latency", n, 2);
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            pops += int'(tx_data_src_rdy && tx_data_dst_rdy);
            cyc(); #1;
        end
        chk("stream_rate", pops, 16);
        drain("stream_drain");

        load(32'h11, 16);
        cyc(4); tx_data_dst_rdy = 0; rd0 = rd_cnt; #1;
        held = tx_data;
        chk("bp_valid", tx_data_src_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("bp_hold", tx_data, held);
            chk("bp_valid_hold", tx_data_src_rdy, 1);
        end
        chk("bp_extra_reads", (rd_cnt - rd0) <= 2, 1);
        cyc(); tx_data_dst_rdy = 1;
        drain("bp_drain");

        tx_data_dst_rdy = 0;
        load(32'h31, 4);
        cyc(4); #1;
        chk("cd_full_valid", tx_data_src_rdy, 1);
        cyc(); channel_rdy = 0; tx_data_dst_rdy = 1; rd0 = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cd_valid", tx_data_src_rdy, 0);
            chk("cd_rd", fifo_rd_o, 0);
            cyc();
        end
        chk("cd_no_reads", rd_cnt - rd0, 0);
        channel_rdy = 1; #1;
        chk("cd_head", tx_data, 32'h31);
        chk("cd_valid_back", tx_data_src_rdy, 1);
        drain("cd_drain");

        load(32'h51, 4);
        rx_exp.push_back(32'hA0); rx_exp.push_back(32'hA1); rx_exp.push_back(32'hA3);
        rx_data_src_rdy = 1; rx_data = 32'hA0;
        cyc(); #1;
        chk("rx_latency", fifo_wr_o, 1);
        rx_data = 32'hA1;
        cyc(); rx_data = 32'hA2; fifo_full_i = 1;
        cyc(); rx_data = 32'hA3; fifo_full_i = 0; #1;
        chk("rx_full_drop", fifo_wr_o, 0);
        cyc(); rx_data_src_rdy = 0;
        drain("rx_drain");
        rx_fifo_rst = 1; rx_data_src_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 32'hB0 + 32'(i);
            cyc(); #1;
            chk("rxrst_wr", fifo_wr_o, 0);
        end
        rx_data_src_rdy = 0; rx_fifo_rst = 0;

        cyc(); tx_data_dst_rdy = 0;
        load(32'h41, 8);
        cyc(3);
        rx_exp.push_back(32'hC0); rx_data_src_rdy = 1; rx_data = 32'hC0;
        cyc(); pll_not_locked = 1; rx_data = 32'hC1; rd0 = rd_cnt; #1;
        chk("pll_rd", fifo_rd_o, 0);
        cyc(); #1;
        chk("pll_valid", tx_data_src_rdy, 0);
        chk("pll_data", tx_data, 0);
        chk("pll_wr", fifo_wr_o, 0);
        chk("pll_wdat", fifo_wr_dat_o, 0);
        chk("pll_reads", rd_cnt - rd0, 0);
        void'(tx_exp.pop_front());
        void'(tx_exp.pop_front());
        cyc(); pll_not_locked = 0; rx_data_src_rdy = 0; tx_data_dst_rdy = 1;
        drain("pll_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
